// File: rtl/seq_sync_pkg.sv
// seq_sync_pkg: constants and types shared by the 11101 sync-word framer.
//   SYNC_WORD/SYNC_LEN : sync pattern, sent MSB first
//   GUARD_LEN          : trailing zero bits per frame (>= 2)
//   HIST_W, STUFF_TRIGGER : line-history width and the pattern that forces a stuff
//   state_t            : framer FSM states
package seq_sync_pkg;

    localparam int          SYNC_LEN      = 5;
    localparam logic [4:0]  SYNC_WORD     = 5'b11101;
    localparam int          GUARD_LEN     = 2;
    localparam int          HIST_W        = 4;
    localparam logic [3:0]  STUFF_TRIGGER = 4'b1110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DATA  = 2'd2,
        GUARD = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_sync_framer_tx_stuff.sv
// seq_stuff_tracker: remembers the last HIST_W bits put on the line and flags
// when the next payload bit would complete the sync word.
//   clock, reset : clock, async active-low reset
//   clear        : frame accepted; history restarts holding only bit_in
//   shift        : a sync/data/stuffed bit is being emitted this edge
//   bit_in       : value of the bit being emitted
//   stuff_req    : history matches STUFF_TRIGGER
module seq_stuff_tracker
    import seq_sync_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic shift,
    input  logic bit_in,
    output logic stuff_req
);

    logic [HIST_W-1:0] hist;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            hist <= '0;
        else if (clear)
            hist <= {{(HIST_W-1){1'b0}}, bit_in};
        else if (shift)
            hist <= {hist[HIST_W-2:0], bit_in};
    end

    assign stuff_req = (hist == STUFF_TRIGGER);

endmodule

// File: rtl/seq_sync_framer_tx.sv
// seq_sync_framer_tx: serial transmitter for the 11101 sync-word protocol.
// Frame on the line: SYNC_WORD, DATA_W payload bits MSB first (with a 0
// stuffed wherever the last four line bits are 1110), then GUARD_LEN zeros.
//   clock, reset : clock, async active-low reset
//   load, din    : frame request / payload, accepted when load && ready
//   ready        : high only in IDLE (0 while reset is low)
//   dataout      : registered serial line, 0 when no frame bit is driven
//   busy         : first sync bit through last guard bit
//   sync_phase   : dataout carries a sync bit
//   stuff_flag   : dataout carries a stuffed bit
//   done         : pulse with the last guard bit
module seq_sync_framer_tx
    import seq_sync_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              dataout,
    output logic              busy,
    output logic              sync_phase,
    output logic              stuff_flag,
    output logic              done
);

    localparam int CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GUARD_LEN)) + 1;
    // The sync tail rides in front of the payload so sync and data bits both
    // leave from the MSB of one shifter.
    localparam int SH_W  = SYNC_LEN - 1 + DATA_W;

    state_t           state;
    logic [CNT_W-1:0] cnt;   // SYNC/GUARD: bits left after the current one; DATA: payload bits left
    logic [SH_W-1:0]  sh;

    logic             accept, sync_step, in_data, do_stuff, do_data;
    logic             stuff_req, hist_shift, hist_bit;
    logic [CNT_W-1:0] rem;

    assign ready     = reset && (state == IDLE);
    assign accept    = load && ready;
    assign sync_step = (state == SYNC) && (cnt != '0);
    assign in_data   = ((state == SYNC) && (cnt == '0)) || (state == DATA);
    // Leaving SYNC, the whole payload is still to go.
    assign rem       = (state == SYNC) ? CNT_W'(DATA_W) : cnt;
    assign do_stuff  = in_data && (rem != '0) && stuff_req;
    assign do_data   = in_data && (rem != '0) && !stuff_req;

    assign hist_shift = accept || sync_step || do_data || do_stuff;
    assign hist_bit   = accept ? SYNC_WORD[SYNC_LEN-1] :
                        do_stuff ? 1'b0 : sh[SH_W-1];

    seq_stuff_tracker u_stuff (
        .clock     (clock),
        .reset     (reset),
        .clear     (accept),
        .shift     (hist_shift),
        .bit_in    (hist_bit),
        .stuff_req (stuff_req)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            dataout    <= 1'b0;
            busy       <= 1'b0;
            sync_phase <= 1'b0;
            stuff_flag <= 1'b0;
            done       <= 1'b0;
        end else begin
            sync_phase <= 1'b0;
            stuff_flag <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    dataout <= 1'b0;
                    busy    <= 1'b0;
                    if (accept) begin
                        state      <= SYNC;
                        cnt        <= CNT_W'(SYNC_LEN - 1);
                        sh         <= {SYNC_WORD[SYNC_LEN-2:0], din};
                        dataout    <= SYNC_WORD[SYNC_LEN-1];
                        busy       <= 1'b1;
                        sync_phase <= 1'b1;
                    end
                end
                SYNC, DATA: begin
                    if (sync_step) begin
                        dataout    <= sh[SH_W-1];
                        sh         <= sh << 1;
                        cnt        <= cnt - 1'b1;
                        sync_phase <= 1'b1;
                    end else if (do_stuff) begin
                        // Stuffed zero: payload and counter hold.
                        state      <= DATA;
                        cnt        <= rem;
                        dataout    <= 1'b0;
                        stuff_flag <= 1'b1;
                    end else if (do_data) begin
                        state   <= DATA;
                        cnt     <= rem - 1'b1;
                        dataout <= sh[SH_W-1];
                        sh      <= sh << 1;
                    end else begin
                        // Payload exhausted: first guard zero, never a stuff.
                        state   <= GUARD;
                        cnt     <= CNT_W'(GUARD_LEN - 1);
                        dataout <= 1'b0;
                    end
                end
                GUARD: begin
                    dataout <= 1'b0;
                    if (cnt != '0) begin
                        cnt  <= cnt - 1'b1;
                        done <= (cnt == CNT_W'(1));
                    end else begin
                        // Line stays 0 for this IDLE cycle, separating frames.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
